// File: rtl/mt_pkg.sv
// Shared MT19937 constants, reader FSM states and the output tempering
// transform used by every block that emits words from the state array.
package mt_pkg;

  localparam int N = 624;

  localparam logic [31:0] TEMPER_B = 32'h9D2C5680;
  localparam logic [31:0] TEMPER_C = 32'hEFC60000;

  localparam int TEMPER_U = 11;
  localparam int TEMPER_S = 7;
  localparam int TEMPER_T = 15;
  localparam int TEMPER_L = 18;

  typedef enum logic {
    REGEN,
    RUN
  } mt_state_e;

  function automatic logic [31:0] temper(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y >> TEMPER_U);
    y = y ^ ((y << TEMPER_S) & TEMPER_B);
    y = y ^ ((y << TEMPER_T) & TEMPER_C);
    y = y ^ (y >> TEMPER_L);
    return y;
  endfunction

endpackage

// File: rtl/mt_temper.sv
// Combinational MT19937 tempering stage, one state word in, one
// tempered word out.
module mt_temper
  import mt_pkg::*;
(
  input  logic [31:0] y_i,
  output logic [31:0] y_o
);

  assign y_o = temper(y_i);

endmodule

// File: rtl/mt_temper_reader.sv
// Walks the MT state array, tempers each word into a valid/ready output
// register and requests a twist after the last word of every pass.
module mt_temper_reader #(
  parameter int N     = mt_pkg::N,
  parameter int IDX_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0][31:0]   state_in,
  output logic                 regen,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [IDX_W-1:0]     idx,
  output logic [31:0]          word_count,
  output logic [15:0]          regen_count
);

  import mt_pkg::*;

  mt_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [31:0]      word_count_q, word_count_d;
  logic [15:0]      regen_count_q, regen_count_d;

  logic        in_regen;
  logic        load;
  logic        accept;
  logic [31:0] tempered;

  mt_temper u_temper (
    .y_i (state_in[idx_q]),
    .y_o (tempered)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    in_regen      = 1'b0;
    load          = 1'b0;
    accept        = out_valid_q && out_ready;

    unique case (state_q)
      REGEN: begin
        in_regen = 1'b1;
        idx_d    = '0;
        state_d  = RUN;
      end
      RUN: begin
        load = !out_valid_q || out_ready;
      end
      default: state_d = REGEN;
    endcase

    // The last index stays put; REGEN rewinds it once the twist is requested.
    if (load) begin
      out_data_d  = tempered;
      out_valid_d = 1'b1;
      if (idx_q == IDX_W'(N - 1)) begin
        state_d = REGEN;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    word_count_d  = word_count_q + 32'(accept);
    regen_count_d = regen_count_q + 16'(in_regen);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= REGEN;
      idx_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      word_count_q  <= '0;
      regen_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      word_count_q  <= word_count_d;
      regen_count_q <= regen_count_d;
    end
  end

  assign regen       = in_regen && !rst;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign idx         = idx_q;
  assign word_count  = word_count_q;
  assign regen_count = regen_count_q;

endmodule

// File: doc/mt_temper_reader.md
MT_TEMPER_READER -- requirements
Module: mt_temper_reader

Interface
REQ-001 Parameter N, default 624: number of 32-bit words in the MT19937 state array.
REQ-002 Parameter IDX_W, default 10: width of the read index, $clog2(N).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 state_in  input  [N-1:0][31:0]  current state array from the state memory; word i = state_in[i].
REQ-006 regen  output  1  one-cycle pulse requesting a twist; drives the state memory load enable.
REQ-007 out_valid  output  1  out_data holds an undelivered tempered word.
REQ-008 out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 out_data  output  32  tempered random word.
REQ-010 idx  output  IDX_W  index of the next state word to be read.
REQ-011 word_count  output  32  number of words accepted since reset; wraps at 2^32.
REQ-012 regen_count  output  16  number of regen pulses since reset; wraps at 2^16.

Function
REQ-013 FSM states: REGEN, RUN; no other states.
REQ-014 REGEN: regen=1 for exactly one cycle; idx<=0; next state RUN.
REQ-015 RUN: regen=0; the output register loads when it is empty (out_valid=0) or being drained (out_valid && out_ready).
REQ-016 Load action: out_data<=temper(state_in[idx]); out_valid<=1; idx<=idx+1.
REQ-017 When a load reads idx=N-1, idx does not increment, and the next state is REGEN.
REQ-018 Temper: y^=y>>11; y^=(y<<7)&32'h9D2C5680; y^=(y<<15)&32'hEFC60000; y^=y>>18. All operations are 32-bit, and upper shifted-out bits are discarded.
REQ-019 Tempering is combinational into the output register; latency is 1 cycle from the load decision to out_valid.
REQ-020 Handshake: once out_valid=1, out_data is held stable until out_valid && out_ready.
REQ-021 If out_valid && out_ready occurs with no load in the same cycle, out_valid<=0.
REQ-022 In REGEN, no load occurs. A pending word (index N-1) stays valid and may be accepted; acceptance clears out_valid.
REQ-023 state_in is sampled only in RUN. The state memory updates at the edge closing the REGEN cycle, so the first RUN cycle reads the new array.
REQ-024 Back-to-back throughput: with out_ready held high, one word per cycle for N cycles, then one bubble cycle (REGEN), repeating. The period is N+1 cycles per N words.
REQ-025 word_count increments on every out_valid && out_ready, including during REGEN.
REQ-026 regen_count increments on every cycle regen=1.
REQ-027 out_ready may be asserted while out_valid=0; it has no effect.

Reset
REQ-028 On rst=1 at a clock edge: state<=REGEN, idx<=0, out_valid<=0, out_data<=0, word_count<=0, regen_count<=0. regen is 0 while rst=1.
REQ-029 After rst deasserts, the first cycle is REGEN. This guarantees a twist is applied to the seeded state before any word is emitted.
REQ-030 rst asserted mid-operation discards any pending output word; out_valid falls at that edge.
REQ-031 The state memory shares clk/rst, so its seeded contents and this block's REGEN-first behaviour align on the same edge.

Structure
REQ-032 The shared package mt_pkg holds N, the tempering constants TEMPER_B=32'h9D2C5680 and TEMPER_C=32'hEFC60000, the shift amounts 11/7/15/18, and the FSM state enum.
REQ-033 The tempering function is placed in mt_pkg, or in one combinational sub-module mt_temper (32-bit in, 32-bit out), reusable by other MT blocks.
REQ-034 The twist/next-state logic is not part of this block.

Verification
REQ-035 Reset then out_ready=1, state_in all zero except word0=32'h1 -> regen pulses in cycle 1 after reset; next cycle out_data=32'h00400091, out_valid=1; following word out_data=0.
REQ-036 out_ready=1 continuously for 2N+2 cycles after reset -> regen is high on cycles 0, N+1 and 2N+2; word_count=2N at end; no duplicate or skipped idx.
REQ-037 out_ready=0 for 10 cycles with out_valid=1 -> out_data unchanged, idx frozen, word_count unchanged.
REQ-038 Word N-1 pending with out_ready=0 entering REGEN -> regen pulses once; word N-1 held; after acceptance the next word is temper(new state_in[0]).
REQ-039 rst asserted mid-stream at idx=300 with out_valid=1 -> next cycle out_valid=0, idx=0, counters 0; the following cycle regen=1.
REQ-040 Random out_ready (50%) against a scoreboard tempering state_in[i] -> every accepted word matches in order across 3 regen periods.
